// File: rtl/png_readback_if.sv
// Port-B RAM read bus and TX-stream handshake between png_readback and its surroundings.
// master = readback engine side, slave = RAM/serializer/control side.
interface png_readback_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  MCU_RX_RDY;
    logic [ADDR_WIDTH-1:0] address_b;
    logic                  rden_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  start,
        input  MCU_RX_RDY,
        input  q_b,
        input  tx_ready,
        output address_b,
        output rden_b,
        output tx_data,
        output tx_valid,
        output busy,
        output done
    );

    modport slave (
        output start,
        output MCU_RX_RDY,
        output q_b,
        output tx_ready,
        input  address_b,
        input  rden_b,
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  done
    );
endinterface

// File: rtl/png_readback.sv
// Streams a stored frame out of image RAM port B, one pixel per valid/ready handshake,
// from address 0 to IMAGE_SIZE-1 after each accepted start pulse.
module png_readback #(
    parameter int IMAGEY           = 64,
    parameter int IMAGEX           = 64,
    parameter int IMAGE_SIZE       = IMAGEY * IMAGEX,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = 8,
    parameter int RAM_LATENCY      = 2
) (
    input  logic           clk,
    input  logic           rst,
    png_readback_if.master bus
);
    localparam int CNT_WIDTH = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] ADDR_ONE  = IMAGE_ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]        CNT_LOAD  = CNT_WIDTH'(RAM_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0]        CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                      state_r, state_s;
    logic [IMAGE_ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                        rden_r, rden_s;
    logic [RGB_SIZE-1:0]         data_r, data_s;
    logic                        valid_r, valid_s;
    logic                        busy_r, busy_s;
    logic                        done_r, done_s;
    logic [CNT_WIDTH-1:0]        cnt_r, cnt_s;

    // Next-state and next-output decode. rden_b is a registered output, so the read
    // strobe is decided on the edge that enters (or stays in) FETCH from MCU_RX_RDY;
    // the FETCH cycle that carries the strobe is then the cycle the RAM samples it.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        rden_s  = 1'b0;
        data_s  = data_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_FETCH;
                    addr_s  = {IMAGE_ADDR_WIDTH{1'b0}};
                    busy_s  = 1'b1;
                    rden_s  = bus.MCU_RX_RDY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (rden_r) begin
                    state_s = ST_WAIT;
                    cnt_s   = CNT_LOAD;
                end else begin
                    rden_s  = bus.MCU_RX_RDY;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                    data_s  = bus.q_b;
                    valid_s = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    valid_s = 1'b0;
                    if (addr_r == LAST_ADDR) begin
                        state_s = ST_DONE;
                        addr_s  = {IMAGE_ADDR_WIDTH{1'b0}};
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = ST_FETCH;
                        addr_s  = addr_r + ADDR_ONE;
                        rden_s  = bus.MCU_RX_RDY;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                addr_s  = {IMAGE_ADDR_WIDTH{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                addr_s  = {IMAGE_ADDR_WIDTH{1'b0}};
                data_s  = {RGB_SIZE{1'b0}};
                valid_s = 1'b0;
                busy_s  = 1'b0;
                cnt_s   = {CNT_WIDTH{1'b0}};
            end
        endcase
    end

    // State and output registers; reset drops any partial frame without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= {IMAGE_ADDR_WIDTH{1'b0}};
            rden_r  <= 1'b0;
            data_r  <= {RGB_SIZE{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            rden_r  <= rden_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            cnt_r   <= cnt_s;
        end
    end

    assign bus.address_b = addr_r;
    assign bus.rden_b    = rden_r;
    assign bus.tx_data   = data_r;
    assign bus.tx_valid  = valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule
